upload_stream_mux: RTL

- Parametrised N-channel upload multiplexer that merges byte streams from capture/measurement engines into the single USB CDC upload byte stream.
- Each channel has its own FIFO. A round-robin arbiter emits framed packets: sync, channel id, length, payload, checksum.
- Generalises the current single-source upload path. Adds channel count, buffering, flow control, timeout flush and overflow reporting.
- Sits between the command/peripheral layer and the USB CDC upload interface, in the 60 MHz PHY clock domain.

---
 rtl/upload_mux_pkg.sv | 18 +
 rtl/upload_ch_fifo.sv | 48 ++++
 rtl/upload_stream_mux.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/upload_mux_pkg.sv
// rtl/upload_mux_pkg.sv - shared types and constants for the upload stream multiplexer
package upload_mux_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC0,
      ST_SYNC1,
      ST_CHID,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM
   } state_t;

   localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
   localparam logic [7:0] SYNC1_DEFAULT = 8'h55;
   localparam int         CHID_W        = 3;

endpackage

// File: rtl/upload_ch_fifo.sv
// rtl/upload_ch_fifo.sv - per-channel byte FIFO with occupancy count and two-deep read peek
module upload_ch_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     rd_en,
   output logic [7:0]               rd_head,
   output logic [7:0]               rd_next,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int            AW   = $clog2(DEPTH);
   localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_wr;
   logic          w_rd;

   assign w_wr    = wr_en && (r_count != FULL);
   assign w_rd    = rd_en && (r_count != '0);
   assign rd_head = r_mem[r_rd_ptr];
   // rd_next lets the drain path present the following byte without a bubble
   assign rd_next = r_mem[r_rd_ptr + AW'(1)];
   assign count   = r_count;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
         else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/upload_stream_mux.sv
// rtl/upload_stream_mux.sv - round-robin framer merging per-channel byte FIFOs into one upload stream
module upload_stream_mux
   import upload_mux_pkg::*;
#(
   parameter int         NUM_CH        = 4,
   parameter int         FIFO_DEPTH    = 16,
   parameter int         MAX_PAYLOAD   = 8,
   parameter int         FLUSH_TIMEOUT = 1000,
   parameter logic [7:0] SYNC0         = SYNC0_DEFAULT,
   parameter logic [7:0] SYNC1         = SYNC1_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_CH*8-1:0]   src_data,
   input  logic [NUM_CH-1:0]     src_valid,
   output logic [NUM_CH-1:0]     src_ready,
   output logic [7:0]            usb_upload_data,
   output logic                  usb_upload_valid,
   input  logic                  usb_upload_ready,
   output logic [NUM_CH-1:0]     overflow,
   input  logic                  ovf_clear,
   output logic                  busy
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

   logic [CW-1:0]     w_count [NUM_CH];
   logic [7:0]        w_head  [NUM_CH];
   logic [7:0]        w_next  [NUM_CH];
   logic [NUM_CH-1:0] w_full;
   logic [NUM_CH-1:0] w_wr;
   logic [NUM_CH-1:0] w_pop;
   logic [NUM_CH-1:0] w_elig;
   logic [TW-1:0]     r_timer [NUM_CH];
   logic [NUM_CH-1:0] r_ovf;

   state_t            r_state;
   logic [CHID_W-1:0] r_ch;
   logic [CHID_W-1:0] r_rr;
   logic [7:0]        r_left;
   logic [7:0]        r_sum;
   logic [7:0]        r_data;
   logic              r_valid;
   logic              r_busy;

   logic              w_arb;
   logic [CHID_W-1:0] w_pick;
   logic [7:0]        w_len;
   logic [7:0]        w_head_sel;
   logic [7:0]        w_next_sel;
   int                w_idx;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      upload_ch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (w_wr[g]),
         .wr_data (src_data[8*g +: 8]),
         .rd_en   (w_pop[g]),
         .rd_head (w_head[g]),
         .rd_next (w_next[g]),
         .count   (w_count[g])
      );
      assign w_full[g] = (w_count[g] == CW'(FIFO_DEPTH));
      assign w_wr[g]   = src_valid[g] && !w_full[g];
      assign w_pop[g]  = (r_state == ST_PAYLOAD) && usb_upload_ready && (r_ch == CHID_W'(g));
      assign w_elig[g] = (w_count[g] >= CW'(MAX_PAYLOAD)) ||
                         ((w_count[g] != '0) && (r_timer[g] == TW'(FLUSH_TIMEOUT)));
   end

   // Scan downward so the last hit is the first eligible channel at or after r_rr
   always_comb begin
      w_arb  = 1'b0;
      w_pick = '0;
      w_len  = '0;
      w_idx  = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         w_idx = int'(r_rr) + i;
         if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
         if (w_elig[w_idx]) begin
            w_arb  = 1'b1;
            w_pick = CHID_W'(w_idx);
            w_len  = (w_count[w_idx] >= CW'(MAX_PAYLOAD)) ? 8'(MAX_PAYLOAD) : 8'(w_count[w_idx]);
         end
      end
      if (r_state != ST_IDLE) w_arb = 1'b0;
   end

   always_comb begin
      w_head_sel = '0;
      w_next_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_ch == CHID_W'(i)) begin
            w_head_sel = w_head[i];
            w_next_sel = w_next[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) r_timer[i] <= '0;
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_wr[i] || (w_count[i] == '0) || (w_arb && (w_pick == CHID_W'(i))))
               r_timer[i] <= '0;
            else if (r_timer[i] != TW'(FLUSH_TIMEOUT))
               r_timer[i] <= r_timer[i] + 1'b1;
         end
         if (ovf_clear) r_ovf <= '0;
         else           r_ovf <= r_ovf | (src_valid & w_full);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ch    <= '0;
         r_rr    <= '0;
         r_left  <= '0;
         r_sum   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_arb) begin
               r_ch    <= w_pick;
               r_left  <= w_len;
               r_rr    <= (w_pick == CHID_W'(NUM_CH - 1)) ? '0 : w_pick + 1'b1;
               r_state <= ST_SYNC0;
               r_data  <= SYNC0;
               r_valid <= 1'b1;
               r_busy  <= 1'b1;
            end
            ST_SYNC0: if (usb_upload_ready) begin
               r_state <= ST_SYNC1;
               r_data  <= SYNC1;
            end
            ST_SYNC1: if (usb_upload_ready) begin
               r_state <= ST_CHID;
               r_data  <= {{(8 - CHID_W){1'b0}}, r_ch};
               r_sum   <= {{(8 - CHID_W){1'b0}}, r_ch};
            end
            ST_CHID: if (usb_upload_ready) begin
               r_state <= ST_LEN;
               r_data  <= r_left;
               r_sum   <= r_sum + r_left;
            end
            ST_LEN: if (usb_upload_ready) begin
               r_state <= ST_PAYLOAD;
               r_data  <= w_head_sel;
               r_sum   <= r_sum + w_head_sel;
            end
            ST_PAYLOAD: if (usb_upload_ready) begin
               r_left <= r_left - 1'b1;
               if (r_left == 8'd1) begin
                  r_state <= ST_CSUM;
                  r_data  <= r_sum;
               end else begin
                  r_data <= w_next_sel;
                  r_sum  <= r_sum + w_next_sel;
               end
            end
            ST_CSUM: if (usb_upload_ready) begin
               r_state <= ST_IDLE;
               r_data  <= '0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign src_ready        = ~w_full;
   assign usb_upload_data  = r_data;
   assign usb_upload_valid = r_valid;
   assign overflow         = r_ovf;
   assign busy             = r_busy;

endmodule
